// File: rtl/nios2_mul_pkg.sv
// nios2_mul_pkg: op encodings, controller states and partial-product alignment
// shared by the sequential multiply controller.
`default_nettype none

package nios2_mul_pkg;

  localparam logic [1:0] MUL_OP_LO  = 2'b00;
  localparam logic [1:0] MUL_OP_XUU = 2'b01;
  localparam logic [1:0] MUL_OP_XSS = 2'b10;
  localparam logic [1:0] MUL_OP_XSU = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIX   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int PP_SHIFT0 = 0;
  localparam int PP_SHIFT1 = 16;
  localparam int PP_SHIFT2 = 16;
  localparam int PP_SHIFT3 = 32;

  // Place partial product idx at its weight inside the 64-bit sum.
  function automatic logic [63:0] pp_align(input logic [1:0] idx, input logic [31:0] p);
    case (idx)
      2'd0:    return {32'd0, p} << PP_SHIFT0;
      2'd1:    return {32'd0, p} << PP_SHIFT1;
      2'd2:    return {32'd0, p} << PP_SHIFT2;
      default: return {32'd0, p} << PP_SHIFT3;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul16x16_reg.sv
// mul16x16_reg: registered unsigned 16x16->32 multiplier, one DSP element.
`default_nettype none

module mul16x16_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) p <= '0;
    else if (en)  p <= a * b;
  end

endmodule

`default_nettype wire

// File: rtl/nios2_seq_mul_ctrl.sv
// nios2_seq_mul_ctrl: sequential 32x32 Nios II multiply (mul/mulxuu/mulxss/mulxsu)
// built from four passes through one registered 16x16 multiplier.
`default_nettype none

module nios2_seq_mul_ctrl
  import nios2_mul_pkg::*;
#(
  parameter int SKIP_HI_FOR_MUL = 1,
  parameter int MULT_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        abort,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy
);

  if (MULT_LATENCY != 1) begin : g_bad_latency
    $error("nios2_seq_mul_ctrl: only MULT_LATENCY=1 is supported");
  end

  state_t      state, state_nxt;
  logic [31:0] src_a, src_b;
  logic [1:0]  op_q;
  logic [1:0]  k;
  logic [63:0] acc;
  logic [31:0] prod;
  logic        mul_en;
  logic [1:0]  last_k;
  logic        add_en;
  logic [1:0]  add_idx;
  logic        signed_a, signed_b;
  logic [31:0] fix_hi;

  assign last_k = ((SKIP_HI_FOR_MUL != 0) && (op_q == MUL_OP_LO)) ? 2'd2 : 2'd3;

  mul16x16_reg u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mul_en),
    .a       (k[1] ? src_a[31:16] : src_a[15:0]),
    .b       (k[0] ? src_b[31:16] : src_b[15:0]),
    .p       (prod)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: if (abort) state_nxt = ST_IDLE;
                else if (k == last_k) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = abort ? ST_IDLE : ST_FIX;
      ST_FIX:   state_nxt = abort ? ST_IDLE : ST_DONE;
      ST_DONE:  if (abort || rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    mul_en    = 1'b0;
    case (state)
      ST_IDLE:  begin req_ready = 1'b1; busy = 1'b0; end
      ST_ISSUE: mul_en = 1'b1;
      ST_DONE:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  // The product register lags issue by one edge, so ISSUE adds product k-1 and DRAIN adds product k.
  assign add_en  = ((state == ST_ISSUE) && (k != 2'd0)) || (state == ST_DRAIN);
  assign add_idx = (state == ST_DRAIN) ? k : k - 2'd1;

  assign signed_a = (op_q == MUL_OP_XSS) || (op_q == MUL_OP_XSU);
  assign signed_b = (op_q == MUL_OP_XSS);
  assign fix_hi   = acc[63:32]
                  - ((signed_a && src_a[31]) ? src_b : 32'd0)
                  - ((signed_b && src_b[31]) ? src_a : 32'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_a      <= '0;
      src_b      <= '0;
      op_q       <= MUL_OP_LO;
      k          <= '0;
      acc        <= '0;
      rsp_result <= '0;
    end else if ((state == ST_IDLE) && req_valid) begin
      src_a <= req_src1;
      src_b <= req_src2;
      op_q  <= req_op;
      k     <= '0;
      acc   <= '0;
    end else begin
      if (add_en)
        acc <= acc + pp_align(add_idx, prod);
      if ((state == ST_ISSUE) && (k != last_k))
        k <= k + 2'd1;
      if ((state == ST_FIX) && !abort)
        rsp_result <= (op_q == MUL_OP_LO) ? acc[31:0] : fix_hi;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nios2_seq_mul_ctrl.sv
// tb_nios2_seq_mul_ctrl: vector table, corner sequences and randomized ops
// checked against an arithmetic model of the Nios II multiply results.
`default_nettype none

module tb_nios2_seq_mul_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        abort = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  nios2_seq_mul_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .abort      (abort),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: full-precision product from sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: begin pu = ua * ub; return pu[31:0]; end
      2'b01: begin pu = ua * ub; return pu[63:32]; end
      2'b10: begin ps = sa * sb; return ps[63:32]; end
      default: begin ps = sa * longint'(ub); return ps[63:32]; end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op);
    return (op == 2'b00) ? 5 : 6;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int bp, input bit abort_at_accept,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    abort = abort_at_accept; rsp_ready = 1'b0;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    abort     = 1'b0;
    req_valid = 1'($urandom);
    req_op    = 2'($urandom);
    req_src1  = $urandom;
    req_src2  = $urandom;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!rsp_valid && lat < 20);
    chk("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    res = rsp_result;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      chk("backpressure_hold", {30'd0, rsp_valid, req_ready, rsp_result}, {30'd0, 1'b1, 1'b0, res});
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("handshake_to_idle", {61'd0, req_ready, rsp_valid, busy}, 64'b100);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [31:0] res;
    int          lat;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    vt[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5};
    vt[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6};
    vt[2] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6};
    vt[3] = '{2'b10, 32'h80000000, 32'h80000000, 32'h40000000, 6};
    vt[4] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6};
    vt[5] = '{2'b11, 32'h00000002, 32'h80000000, 32'h00000001, 6};
    vt[6] = '{2'b00, 32'h00012345, 32'h00010000, 32'h23450000, 5};
    vt[7] = '{2'b10, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 6};
    vt[8] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 6};
    vt[9] = '{2'b00, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 5};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {29'd0, req_ready, rsp_valid, busy, rsp_result}, {29'd0, 3'b100, 32'd0});
    @(negedge clk);
    reset_n = 1'b1;

    // Asynchronous reset while in ISSUE.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'h12345678; req_src2 = 32'h9ABCDEF0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("reset_mid_issue", {61'd0, req_ready, rsp_valid, busy}, 64'b100);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen++;
      end
      chk("no_rsp_after_reset", seen, 0);
    end
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, res, lat);
    chk("post_reset_xuu_result", res, 32'hFFFFFFFE);
    chk("post_reset_xuu_latency", lat, 6);

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, 0, 1'b0, res, lat);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
    end

    // Back-pressure for 5 cycles.
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, res, lat);
    chk("bp_result", res, 32'hFFFFFFFF);

    // Abort raised in IDLE together with a request: request still taken.
    run_op(2'b10, 32'h80000000, 32'h80000000, 0, 1'b1, res, lat);
    chk("idle_abort_result", res, 32'h40000000);
    chk("idle_abort_latency", lat, 6);

    // Abort in FIX: five edges after acceptance an MULX op sits in FIX.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_src1 = 32'hFFFFFFFF; req_src2 = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("in_fix_state", {62'd0, busy, rsp_valid}, 64'b10);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_fix_idle", {61'd0, req_ready, rsp_valid, busy}, 64'b100);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (rsp_valid) seen++;
      end
      chk("no_rsp_after_abort", seen, 0);
    end
    run_op(2'b00, 32'h00012345, 32'h00010000, 0, 1'b0, res, lat);
    chk("post_abort_mul_result", res, 32'h23450000);
    chk("post_abort_mul_latency", lat, 5);

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      rb = (i % 5 == 0) ? 32'h7FFFFFFF : $urandom;
      run_op(rop, ra, rb, int'($urandom_range(0, 2)), 1'b0, res, lat);
      chk($sformatf("rand%0d_op%0d_result", i, rop), res, ref_mul(rop, ra, rb));
      chk($sformatf("rand%0d_latency", i), lat, ref_lat(rop));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
